mem_arbiter: RTL
================

# mem_arbiter

Multi-core memory arbiter between the per-core instruction/data caches and the single-ported RAM. Each core's icache and dcache present word requests on the cache-control side. The arbiter grants one requester at a time and drives the RAM strobes and address from the winner. It holds the grant across the dcache's multi-word block fetch, writeback and flush sequences, and releases it when the requester drops its strobes. Dcache traffic has priority over icache traffic; requesters of the same class are served round-robin.

## Interface
- CPUS, 2, number of cores; each core has one icache port and one dcache port.
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  CPUS  icache read request, one bit per core.
- iaddr  in  CPUS×32  icache word address.
- iload  out  CPUS×32  instruction data; every element = ramload.
- iwait  out  CPUS  icache stall; 0 only for the granted core when the RAM is in ACCESS.
- dREN, dWEN  in  CPUS each  dcache read/write request.
- daddr, dstore  in  CPUS×32 each  dcache address and write data.
- dload  out  CPUS×32  data read; every element = ramload.
- dwait  out  CPUS  dcache stall; same rule as iwait.
- ramREN, ramWEN  out  1 each  RAM strobes.
- ramaddr, ramstore  out  32 each  RAM address and write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- ram_err  out  1  sticky; set on any cycle with ramstate==ERROR while a grant is held.

## Operation
- States: IDLE, GRANT_D, GRANT_I. Registers:
  - gidx: granted core, log2(CPUS) bits, minimum 1.
  - rr_d, rr_i: round-robin pointers.
  - ram_err.
- IDLE transitions:
  - Any dREN|dWEN asserted → GRANT_D. gidx = first core with a dcache request, searching from rr_d upward and wrapping modulo CPUS.
  - Otherwise any iREN asserted → GRANT_I. gidx is chosen the same way using rr_i.
  - Otherwise stay in IDLE.
- GRANT_D:
  - ramWEN = dWEN[gidx]. ramREN = dREN[gidx] & ~dWEN[gidx]; write wins if both are asserted.
  - ramaddr = daddr[gidx]. ramstore = dstore[gidx].
  - dwait[gidx] = (ramstate != ACCESS).
- GRANT_I:
  - ramREN = iREN[gidx]. ramWEN = 0. ramaddr = iaddr[gidx]. ramstore = 0.
  - iwait[gidx] = (ramstate != ACCESS).
- Release:
  - In GRANT_D, when dREN[gidx]|dWEN[gidx] = 0, the RAM strobes drop the same cycle (combinational). Next state is IDLE and rr_d ← gidx+1 mod CPUS.
  - GRANT_I releases the same way on iREN[gidx]=0 and updates rr_i.
- Non-granted ports: wait=1 in every state, including IDLE.
- ERROR status: treated as not-ACCESS, so wait stays 1 and the grant is held. ram_err is set and cleared only by reset.
- Addresses pass through unmodified; the arbiter neither checks nor realigns them.

## Timing
- Reset (asynchronous) values:
  - state=IDLE, gidx=0, rr_d=0, rr_i=0, ram_err=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - All iwait=1 and all dwait=1.
  - iload/dload follow ramload (combinational).
- Arbitration latency:
  - A request that appears in IDLE at cycle 0 is granted on the next edge; RAM strobes assert in cycle 1.
  - The earliest wait=0 is cycle 1, if ramstate==ACCESS that cycle.
- Within a grant: the requester may change the address or switch between read and write with no gap. Example: dcache wb1→wb2→fetch1→fetch2 runs as one uninterrupted grant.
- After release there is one dead IDLE cycle, so back-to-back grants to different requesters are at least 1 cycle apart.
- Priority:
  - Simultaneous dcache and icache requests in IDLE → dcache wins.
  - An icache request waits while any dcache request is pending at an IDLE decision.
- Reset mid-grant: the grant is dropped immediately (asynchronous). Any partial block transfer is abandoned; the caches restart from their own reset.
- Wrap-around: a pointer equal to CPUS-1 advances to 0.

## Test plan
- Reset, then dREN[0]=1, daddr[0]=0x100, ramstate=ACCESS from cycle 1 → ramREN=1 and ramaddr=0x100 in cycle 1; dwait[0]=0; dload[0]=ramload; dwait[1]=1, iwait=2'b11.
- iREN[0]=1 and dWEN[1]=1 in the same IDLE cycle, dstore[1]=0xDEADBEEF → core-1 dcache is granted: ramWEN=1, ramstore=0xDEADBEEF; iwait[0]=1 until dWEN[1] drops, then the icache is granted 2 cycles later.
- Dcache two-word writeback then fetch: dWEN at 0x40, then 0x44, then dREN at 0x80, then 0x84, with ramstate=BUSY for 2 cycles before each ACCESS → one continuous grant, no IDLE cycle, 4 word accesses, dwait low for exactly 4 cycles.
- Both dcaches request continuously, each releasing after 1 word:
  - Required grant order: 0, 1, 0, 1.
  - rr_d must wrap from 1 to 0.
- ramstate=ERROR for 1 cycle during a grant → wait stays 1 that cycle; ram_err=1 and remains 1 after the grant ends until nRST.
- nRST asserted while GRANT_D is mid-fetch → ramREN=0, all waits=1 and state=IDLE immediately. After deassertion, a new iREN[1] is granted to core 1 with rr_i=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter for per-core icache/dcache ports.
// Dcache requests win over icache requests; within a class, cores are served round-robin.
module mem_arbiter #(
  parameter int CPUS = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0][31:0]  iaddr,
  output logic [CPUS-1:0][31:0]  iload,
  output logic [CPUS-1:0]        iwait,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  output logic [CPUS-1:0][31:0]  dload,
  output logic [CPUS-1:0]        dwait,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  logic [1:0]             ramstate,
  output logic                   ram_err
);

  localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gidx_q, gidx_d;
  logic [GW-1:0]   rr_d_q, rr_d_d;
  logic [GW-1:0]   rr_i_q, rr_i_d;
  logic            ram_err_q, ram_err_d;
  logic [CPUS-1:0] dreq_s;
  logic            access_s;

  // Pointer one past the granted core, wrapping at CPUS.
  function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] p);
    if (int'(p) >= CPUS - 1) begin
      next_ptr = '0;
    end else begin
      next_ptr = p + GW'(1);
    end
  endfunction

  // First requester at or above ptr, wrapping modulo CPUS.
  function automatic logic [GW-1:0] pick_rr(input logic [CPUS-1:0] req,
                                            input logic [GW-1:0]   ptr);
    logic found;
    int   j;
    pick_rr = ptr;
    found   = 1'b0;
    for (int k = 0; k < CPUS; k++) begin
      j = (int'(ptr) + k) % CPUS;
      if (!found && req[j]) begin
        pick_rr = GW'(j);
        found   = 1'b1;
      end
    end
  endfunction

  // Arbiter state, grant index, round-robin pointers and sticky error flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      gidx_q    <= '0;
      rr_d_q    <= '0;
      rr_i_q    <= '0;
      ram_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gidx_q    <= gidx_d;
      rr_d_q    <= rr_d_d;
      rr_i_q    <= rr_i_d;
      ram_err_q <= ram_err_d;
    end
  end

  // Next-state decision and RAM/wait steering from the granted port.
  always_comb begin
    state_d   = state_q;
    gidx_d    = gidx_q;
    rr_d_d    = rr_d_q;
    rr_i_d    = rr_i_q;
    ram_err_d = ram_err_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = 32'h0000_0000;
    ramstore  = 32'h0000_0000;
    iwait     = '1;
    dwait     = '1;
    dreq_s    = dREN | dWEN;
    access_s  = (ramstate == RAM_ACCESS);

    case (state_q)
      IDLE: begin
        if (|dreq_s) begin
          state_d = GRANT_D;
          gidx_d  = pick_rr(dreq_s, rr_d_q);
        end else if (|iREN) begin
          state_d = GRANT_I;
          gidx_d  = pick_rr(iREN, rr_i_q);
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_D: begin
        // Write wins when a dcache raises both strobes.
        ramWEN         = dWEN[gidx_q];
        ramREN         = dREN[gidx_q] & ~dWEN[gidx_q];
        ramaddr        = daddr[gidx_q];
        ramstore       = dstore[gidx_q];
        dwait[gidx_q]  = ~access_s;
        if (!dreq_s[gidx_q]) begin
          state_d = IDLE;
          rr_d_d  = next_ptr(gidx_q);
        end else begin
          state_d = GRANT_D;
        end
      end
      GRANT_I: begin
        ramREN         = iREN[gidx_q];
        ramaddr        = iaddr[gidx_q];
        iwait[gidx_q]  = ~access_s;
        if (!iREN[gidx_q]) begin
          state_d = IDLE;
          rr_i_d  = next_ptr(gidx_q);
        end else begin
          state_d = GRANT_I;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q != IDLE) && (ramstate == RAM_ERROR)) begin
      ram_err_d = 1'b1;
    end else begin
      ram_err_d = ram_err_q;
    end
  end

  // Load data is broadcast to every cache port.
  always_comb begin
    for (int i = 0; i < CPUS; i++) begin
      iload[i] = ramload;
      dload[i] = ramload;
    end
  end

  assign ram_err = ram_err_q;

endmodule
